// File: rtl/uart_rx_deser.sv
// Oversampling UART receiver: takes the asynchronous rxd line and delivers
// complete bytes (8 data bits, optional parity) to the RX FIFO, with error pulses.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge (start bit)
// START  | checking the middle of the start bit, rejects glitches
// DATA   | shifting in D0..D7, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, pushing the byte or flagging errors
// BREAK  | line held low after a 0x00 frame error, waiting for it to go high
module uart_rx_deser #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_full,
    output logic                 uart_write,
    output logic [7:0]           uart_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_END = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic                 rxd_meta, rxd_s, rxd_d;
    logic [DIV_WIDTH-1:0] div_q, tick_cnt;
    logic                 par_en_q, par_odd_q, par_bad_q;
    logic [SW-1:0]        samp_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift_q;
    logic                 tick, fall, at_mid, at_end;
    logic                 write_d, perr_d, ferr_d, ovr_d;

    assign tick   = (tick_cnt == div_q);
    assign fall   = rxd_d & ~rxd_s;
    assign at_mid = tick && (samp_cnt == SAMP_MID);
    assign at_end = tick && (samp_cnt == SAMP_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_d    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_d    <= rxd_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        write_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            IDLE:   if (fall) state_d = START;
            START:  if (at_mid) state_d = rxd_s ? IDLE : DATA;
            DATA:   if (at_end && bit_cnt == 3'd7) state_d = par_en_q ? PARITY : STOP;
            PARITY: if (at_end) state_d = STOP;
            STOP: begin
                if (at_end) begin
                    if (rxd_s) begin
                        write_d = ~rx_full;
                        ovr_d   = rx_full;
                        perr_d  = par_bad_q;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = (shift_q == 8'h00) ? BREAK : IDLE;
                    end
                end
            end
            BREAK:  if (rxd_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The start sample restarts the sample counter so later samples land mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bad_q <= 1'b0;
            tick_cnt  <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= 3'd0;
            shift_q   <= 8'h00;
            uart_data <= 8'h00;
        end else if (state_q == IDLE) begin
            if (fall) begin
                div_q     <= baud_div;
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
                par_bad_q <= 1'b0;
                tick_cnt  <= '0;
                samp_cnt  <= '0;
                bit_cnt   <= 3'd0;
            end
        end else if (state_q != BREAK) begin
            tick_cnt <= tick ? '0 : tick_cnt + DIV_WIDTH'(1);
            if (tick) begin
                if ((state_q == START && at_mid) || samp_cnt == SAMP_END) samp_cnt <= '0;
                else samp_cnt <= samp_cnt + SW'(1);
            end
            if (state_q == DATA && at_end) begin
                shift_q <= {rxd_s, shift_q[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state_q == PARITY && at_end) par_bad_q <= rxd_s ^ (^shift_q) ^ par_odd_q;
            if (state_q == STOP && at_end) uart_data <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_write  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            uart_write  <= write_d;
            parity_err  <= perr_d;
            frame_err   <= ferr_d;
            overrun_err <= ovr_d;
            rx_busy     <= (state_d != IDLE);
        end
    end

endmodule
